udp_audio_writer: RTL and testbench

UDP_AUDIO_WRITER -- requirements
Module: udp_audio_writer

---
 rtl/udp_audio_writer.sv | 177 +++++++++++++++++
 tb/tb_udp_audio_writer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_audio_writer.sv
`default_nettype none
// ============================================================================
// Module   : udp_audio_writer
// Purpose  : Parses UDP audio packets and writes PCM samples to a FIFO bank.
//            Each packet has a 4-byte big-endian header {MAGIC, LEN} and then
//            LEN little-endian 16-bit samples. A valid header enters PAY. A
//            bad header pulses hdr_err and skips the rest of the packet.
// Ports    : wr_clk, sys_rst_n          - clock, async active-low reset
//            rec_en, rec_data           - payload byte stream
//            rec_pkt_done               - end-of-packet pulse
//            fifo_full                  - selected FIFO full flag
//            wr_en, wr_data             - FIFO write strobe / sample
//            pkt_cnt, drop_cnt          - saturating good-packet / drop counts
//            hdr_err, len_err           - bad-header / short-packet pulses
// Revision : 1.0 - initial release
// ============================================================================
module udp_audio_writer #(
    parameter logic [15:0] MAGIC       = 16'hA55A,
    parameter logic [15:0] MAX_SAMPLES = 16'd1024
) (
    input  logic        wr_clk,
    input  logic        sys_rst_n,
    input  logic        rec_en,
    input  logic [7:0]  rec_data,
    input  logic        rec_pkt_done,
    input  logic        fifo_full,
    output logic        wr_en,
    output logic [15:0] wr_data,
    output logic [15:0] pkt_cnt,
    output logic [15:0] drop_cnt,
    output logic        hdr_err,
    output logic        len_err
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_HDR  = 2'd1;
    localparam logic [1:0] c_PAY  = 2'd2;
    localparam logic [1:0] c_SKIP = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [1:0]  r_byte_idx;
    logic [7:0]  r_hdr0;
    logic [7:0]  r_hdr1;
    logic [7:0]  r_hdr2;
    logic [15:0] r_sample_left;
    logic        r_phase;      // 0: expecting low byte, 1: expecting high byte
    logic [7:0]  r_low;

    logic [15:0] w_len;
    logic        w_hdr_last;
    logic        w_hdr_ok;
    logic        w_high;
    logic        w_last;
    logic        w_write;
    logic        w_drop;
    logic        w_hdr_bad;
    logic        w_len_short;

    // The final header byte is taken straight from rec_data so the length
    // check happens in the same cycle the byte arrives.
    assign w_len = {r_hdr2, rec_data};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge wr_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: the byte is processed first, then rec_pkt_done
    // overrides the result and forces IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: if (rec_en) w_state_nxt = c_HDR;
            c_HDR:  if (w_hdr_last) w_state_nxt = w_hdr_ok ? c_PAY : c_SKIP;
            c_PAY:  if (w_last) w_state_nxt = c_SKIP;
            c_SKIP: w_state_nxt = c_SKIP;
            default: w_state_nxt = c_IDLE;
        endcase
        if (rec_pkt_done) begin
            w_state_nxt = c_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Output / event decode
    // ------------------------------------------------------------------
    always_comb begin
        w_hdr_last  = (r_state == c_HDR) && rec_en && (r_byte_idx == 2'd3);
        w_hdr_ok    = ({r_hdr0, r_hdr1} == MAGIC) && (w_len != 16'd0) &&
                      (w_len <= MAX_SAMPLES);
        w_high      = (r_state == c_PAY) && rec_en && r_phase;
        w_last      = w_high && (r_sample_left == 16'd1);
        w_write     = w_high && !fifo_full;
        w_drop      = w_high && fifo_full;
        w_hdr_bad   = w_hdr_last && !w_hdr_ok;
        // A packet completed by a byte coinciding with rec_pkt_done is not short.
        w_len_short = rec_pkt_done && (r_state == c_PAY) && !w_last;
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge wr_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_byte_idx    <= 2'd0;
            r_hdr0        <= 8'h00;
            r_hdr1        <= 8'h00;
            r_hdr2        <= 8'h00;
            r_sample_left <= 16'd0;
            r_phase       <= 1'b0;
            r_low         <= 8'h00;
            wr_en         <= 1'b0;
            wr_data       <= 16'h0000;
            pkt_cnt       <= 16'd0;
            drop_cnt      <= 16'd0;
            hdr_err       <= 1'b0;
            len_err       <= 1'b0;
        end else begin
            wr_en   <= w_write;
            hdr_err <= w_hdr_bad;
            len_err <= w_len_short;

            if (r_state == c_IDLE && rec_en) begin
                r_hdr0     <= rec_data;
                r_byte_idx <= 2'd1;
            end

            if (r_state == c_HDR && rec_en) begin
                if (r_byte_idx == 2'd1) r_hdr1 <= rec_data;
                if (r_byte_idx == 2'd2) r_hdr2 <= rec_data;
                r_byte_idx <= r_byte_idx + 2'd1;
                if (w_hdr_last && w_hdr_ok) begin
                    r_sample_left <= w_len;
                    r_phase       <= 1'b0;
                end
            end

            if (r_state == c_PAY && rec_en) begin
                r_phase <= ~r_phase;
                if (!r_phase) begin
                    r_low <= rec_data;
                end else begin
                    r_sample_left <= r_sample_left - 16'd1;
                end
            end

            // wr_data only moves with a real write so it holds across drops.
            if (w_write) begin
                wr_data <= {rec_data, r_low};
            end

            if (w_drop && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end

            if (w_last && pkt_cnt != 16'hFFFF) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end

            // Any pending low byte is abandoned with the packet.
            if (rec_pkt_done) begin
                r_phase <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_udp_audio_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_udp_audio_writer
// Purpose  : Directed self-checking bench for udp_audio_writer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_udp_audio_writer;

    logic        wr_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        rec_en = 1'b0;
    logic [7:0]  rec_data = 8'h00;
    logic        rec_pkt_done = 1'b0;
    logic        fifo_full = 1'b0;
    logic        wr_en;
    logic [15:0] wr_data;
    logic [15:0] pkt_cnt;
    logic [15:0] drop_cnt;
    logic        hdr_err;
    logic        len_err;

    int checks = 0;
    int errors = 0;

    // Pulse counters sampled on the falling edge, away from output updates.
    int   n_wr  = 0;
    int   n_hdr = 0;
    int   n_len = 0;
    int   n_dbl = 0;
    logic prev_wr = 1'b0;

    udp_audio_writer #(
        .MAGIC       (16'hA55A),
        .MAX_SAMPLES (16'd1024)
    ) dut (
        .wr_clk       (wr_clk),
        .sys_rst_n    (sys_rst_n),
        .rec_en       (rec_en),
        .rec_data     (rec_data),
        .rec_pkt_done (rec_pkt_done),
        .fifo_full    (fifo_full),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .pkt_cnt      (pkt_cnt),
        .drop_cnt     (drop_cnt),
        .hdr_err      (hdr_err),
        .len_err      (len_err)
    );

    always #4 wr_clk = ~wr_clk;

    always @(negedge wr_clk) begin
        if (wr_en) n_wr <= n_wr + 1;
        if (hdr_err) n_hdr <= n_hdr + 1;
        if (len_err) n_len <= n_len + 1;
        if (wr_en && prev_wr) n_dbl <= n_dbl + 1;
        prev_wr <= wr_en;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of stimulus, returns #1 after the capturing edge.
    task automatic cyc(input logic en, input logic [7:0] b, input logic full, input logic done);
        @(negedge wr_clk);
        rec_en       = en;
        rec_data     = b;
        fifo_full    = full;
        rec_pkt_done = done;
        @(posedge wr_clk);
        #1;
        rec_en       = 1'b0;
        rec_pkt_done = 1'b0;
        fifo_full    = 1'b0;
    endtask

    task automatic send_hdr(input logic [15:0] magic, input logic [15:0] len);
        cyc(1'b1, magic[15:8], 1'b0, 1'b0);
        cyc(1'b1, magic[7:0],  1'b0, 1'b0);
        cyc(1'b1, len[15:8],   1'b0, 1'b0);
        cyc(1'b1, len[7:0],    1'b0, 1'b0);
    endtask

    task automatic send_sample(input logic [15:0] s, input logic full, input logic done);
        cyc(1'b1, s[7:0],  1'b0, 1'b0);
        cyc(1'b1, s[15:8], full, done);
    endtask

    task automatic done_pulse();
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        int w0;
        int h0;
        int l0;

        // ---------------- reset state ----------------
        #1;
        chk("rst_wr_en",    wr_en,    1'b0);
        chk("rst_wr_data",  wr_data,  16'h0000);
        chk("rst_pkt_cnt",  pkt_cnt,  16'd0);
        chk("rst_drop_cnt", drop_cnt, 16'd0);
        chk("rst_hdr_err",  hdr_err,  1'b0);
        chk("rst_len_err",  len_err,  1'b0);
        repeat (2) @(negedge wr_clk);
        sys_rst_n = 1'b1;

        // ---------------- good packet, LEN=2 ----------------
        w0 = n_wr; h0 = n_hdr;
        send_hdr(16'hA55A, 16'd2);
        cyc(1'b1, 8'h34, 1'b0, 1'b0);
        chk("good_no_wr_on_low", wr_en, 1'b0);
        cyc(1'b1, 8'h12, 1'b0, 1'b0);
        chk("good_wr_en_1",   wr_en,   1'b1);
        chk("good_wr_data_1", wr_data, 16'h1234);
        cyc(1'b1, 8'h78, 1'b0, 1'b0);
        chk("good_wr_en_gap", wr_en,   1'b0);
        chk("good_hold_data", wr_data, 16'h1234);
        cyc(1'b1, 8'h56, 1'b0, 1'b0);
        chk("good_wr_en_2",   wr_en,   1'b1);
        chk("good_wr_data_2", wr_data, 16'h5678);
        chk("good_pkt_cnt",   pkt_cnt, 16'd1);
        done_pulse();
        chk("good_writes",   n_wr - w0,  2);
        chk("good_no_hdr",   n_hdr - h0, 0);

        // ---------------- bad magic ----------------
        w0 = n_wr; h0 = n_hdr;
        send_hdr(16'hA55B, 16'd2);
        chk("badmagic_hdr_err", hdr_err, 1'b1);
        send_sample(16'h1234, 1'b0, 1'b0);
        send_sample(16'h5678, 1'b0, 1'b0);
        done_pulse();
        chk("badmagic_hdr_once", n_hdr - h0, 1);
        chk("badmagic_no_wr",    n_wr - w0,  0);
        chk("badmagic_pkt_cnt",  pkt_cnt,    16'd1);
        send_hdr(16'hA55A, 16'd1);
        send_sample(16'hABCD, 1'b0, 1'b0);
        chk("after_bad_wr_data", wr_data, 16'hABCD);
        chk("after_bad_pkt_cnt", pkt_cnt, 16'd2);
        done_pulse();

        // ---------------- length bounds ----------------
        h0 = n_hdr; w0 = n_wr;
        send_hdr(16'hA55A, 16'd0);
        chk("len0_hdr_err", hdr_err, 1'b1);
        done_pulse();
        send_hdr(16'hA55A, 16'd1025);
        chk("len1025_hdr_err", hdr_err, 1'b1);
        send_sample(16'h1111, 1'b0, 1'b0);
        done_pulse();
        chk("len_bad_count", n_hdr - h0, 2);
        chk("len_bad_no_wr", n_wr - w0,  0);

        w0 = n_wr;
        send_hdr(16'hA55A, 16'd1024);
        for (int i = 0; i < 1024; i++) begin
            send_sample(16'(i * 3 + 1), 1'b0, 1'b0);
        end
        chk("len1024_last_data", wr_data, 16'h0BFE);
        chk("len1024_pkt_cnt",   pkt_cnt, 16'd3);
        done_pulse();
        chk("len1024_writes", n_wr - w0, 1024);

        // ---------------- backpressure ----------------
        w0 = n_wr;
        send_hdr(16'hA55A, 16'd4);
        send_sample(16'h1111, 1'b0, 1'b0);
        send_sample(16'h2222, 1'b1, 1'b0);
        chk("bp_drop_no_wr",  wr_en,   1'b0);
        chk("bp_drop_hold",   wr_data, 16'h1111);
        send_sample(16'h3333, 1'b1, 1'b0);
        send_sample(16'h4444, 1'b0, 1'b0);
        chk("bp_last_data", wr_data,  16'h4444);
        chk("bp_drop_cnt",  drop_cnt, 16'd2);
        chk("bp_pkt_cnt",   pkt_cnt,  16'd4);
        done_pulse();
        chk("bp_writes", n_wr - w0, 2);

        // ---------------- short packet ----------------
        w0 = n_wr; l0 = n_len;
        send_hdr(16'hA55A, 16'd3);
        send_sample(16'hA001, 1'b0, 1'b0);
        cyc(1'b1, 8'h02, 1'b0, 1'b0);
        done_pulse();
        chk("short_len_err",  len_err,  1'b1);
        chk("short_pkt_cnt",  pkt_cnt,  16'd4);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("short_writes",   n_wr - w0, 1);
        chk("short_len_once", n_len - l0, 1);

        // ---------------- last high byte with rec_pkt_done ----------------
        l0 = n_len;
        send_hdr(16'hA55A, 16'd1);
        send_sample(16'hAA55, 1'b0, 1'b1);
        chk("overlap_wr_en",   wr_en,   1'b1);
        chk("overlap_wr_data", wr_data, 16'hAA55);
        chk("overlap_len_err", len_err, 1'b0);
        chk("overlap_pkt_cnt", pkt_cnt, 16'd5);
        // FSM must already be idle: next header accepted with no extra done.
        send_hdr(16'hA55A, 16'd1);
        send_sample(16'hF00F, 1'b0, 1'b0);
        chk("overlap_next_data", wr_data, 16'hF00F);
        chk("overlap_next_pkt",  pkt_cnt, 16'd6);
        done_pulse();
        chk("overlap_no_len", n_len - l0, 0);

        // ---------------- reset mid-payload ----------------
        send_hdr(16'hA55A, 16'd2);
        cyc(1'b1, 8'h77, 1'b0, 1'b0);
        @(negedge wr_clk);
        #1;
        sys_rst_n = 1'b0;
        #1;
        chk("midrst_wr_data",  wr_data,  16'h0000);
        chk("midrst_pkt_cnt",  pkt_cnt,  16'd0);
        chk("midrst_drop_cnt", drop_cnt, 16'd0);
        chk("midrst_wr_en",    wr_en,    1'b0);
        @(negedge wr_clk);
        sys_rst_n = 1'b1;
        w0 = n_wr;
        cyc(1'b1, 8'h99, 1'b0, 1'b0);
        cyc(1'b1, 8'h88, 1'b0, 1'b0);
        done_pulse();
        chk("midrst_no_wr", n_wr - w0, 0);
        send_hdr(16'hA55A, 16'd1);
        send_sample(16'h1357, 1'b0, 1'b0);
        chk("midrst_new_data", wr_data, 16'h1357);
        chk("midrst_new_pkt",  pkt_cnt, 16'd1);
        done_pulse();

        chk("no_double_wr", n_dbl, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
